// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding, parity helper.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high line.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b1;
      synced <= 1'b1;
    end else begin
      meta   <= line;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive channel: 8E1 deserialiser timed by the 16x sample_ENABLE strobe.
module uart_receiver
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  input  logic                 sample_ENABLE,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR
);

  logic                 rxd_s;
  state_t               state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 armed;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 bit_end;

  uart_sync2 u_sync (
    .clk    (clk),
    .reset  (reset),
    .line   (RxD),
    .synced (rxd_s)
  );

  assign bit_end = (tick_cnt == TICK_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    Rx_VALID  <= 1'b0;
    Rx_PERROR <= 1'b0;
    Rx_FERROR <= 1'b0;
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      armed    <= 1'b0;
      shift    <= '0;
      perr     <= 1'b0;
      Rx_DATA  <= '0;
    end else if (!Rx_EN && state != IDLE) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (sample_ENABLE) begin
      case (state)
        IDLE: begin
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (armed && Rx_EN) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          // Mid-start check rejects glitches shorter than half a bit.
          if (tick_cnt == TICK_W'(MID_TICK)) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rxd_s ? IDLE : DATA;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        DATA: begin
          tick_cnt <= tick_cnt + TICK_W'(1);
          if (bit_end) begin
            shift[bit_cnt] <= rxd_s;
            bit_cnt        <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) state <= PARITY;
          end
        end
        PARITY: begin
          tick_cnt <= tick_cnt + TICK_W'(1);
          if (bit_end) begin
            perr  <= rxd_s ^ even_parity(shift);
            state <= STOP;
          end
        end
        STOP: begin
          tick_cnt <= tick_cnt + TICK_W'(1);
          // Finish at mid-stop so a back-to-back start edge is not missed.
          if (bit_end) begin
            if (rxd_s && !perr) begin
              Rx_DATA  <= shift;
              Rx_VALID <= 1'b1;
            end
            Rx_PERROR <= perr;
            Rx_FERROR <= ~rxd_s;
            armed     <= rxd_s;
            tick_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames, monitor pops expected pulses.
module tb_uart_receiver;

  localparam int TICK_DIV = 27;
  localparam int BIT_CLK  = 16 * TICK_DIV;
  localparam int LAT_LO   = 168 * TICK_DIV;
  localparam int LAT_HI   = LAT_LO + TICK_DIV + 8;
  localparam int GAP_NOM  = 11 * BIT_CLK;

  logic       clk = 1'b0;
  logic       reset;
  logic       Rx_EN;
  logic       RxD;
  logic       sample_ENABLE;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  typedef struct {
    logic       v;
    logic       pe;
    logic       fe;
    logic [7:0] data;
    int         lat;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  int   frame_start = 0;
  int   last_pulse  = 0;

  uart_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .Rx_EN         (Rx_EN),
    .RxD           (RxD),
    .sample_ENABLE (sample_ENABLE),
    .Rx_DATA       (Rx_DATA),
    .Rx_VALID      (Rx_VALID),
    .Rx_PERROR     (Rx_PERROR),
    .Rx_FERROR     (Rx_FERROR)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stand-in for baud_controller at baud_select=3'b111
  initial begin
    sample_ENABLE = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      sample_ENABLE = 1'b1;
      @(negedge clk);
      sample_ENABLE = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input logic v, input logic pe, input logic fe, input logic [7:0] d,
                      input int lat, input int gap);
    exp_t e;
    e.v = v; e.pe = pe; e.fe = fe; e.data = d; e.lat = lat; e.gap = gap;
    sb.push_back(e);
  endtask

  // Caller is positioned at a negedge; each bit lasts BIT_CLK clocks.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    frame_start = cyc;
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (Rx_VALID || Rx_PERROR || Rx_FERROR) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_pulse: got v/pe/fe=%b%b%b expected none (cycle %0d)",
                 Rx_VALID, Rx_PERROR, Rx_FERROR, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_flags", 32'({Rx_VALID, Rx_PERROR, Rx_FERROR}), 32'({e.v, e.pe, e.fe}));
        check("rx_data", 32'(Rx_DATA), 32'(e.data));
        if (e.lat > 0) check_range("latency", cyc - frame_start, e.lat, LAT_HI);
        if (e.gap > 0) check_range("b2b_gap", cyc - last_pulse, e.gap - TICK_DIV, e.gap + TICK_DIV);
      end
      last_pulse = cyc;
    end
  end

  initial begin
    reset = 1'b1;
    Rx_EN = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(Rx_DATA), 32'h0);
    check("reset_flags", 32'({Rx_VALID, Rx_PERROR, Rx_FERROR}), 32'h0);
    reset = 1'b0;
    idle_bits(1);

    // Good frame
    push(1'b1, 1'b0, 1'b0, 8'hA5, LAT_LO, 0);
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(1);

    // Parity error keeps previous data
    push(1'b0, 1'b1, 1'b0, 8'hA5, 0, 0);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_bits(1);

    // Framing error followed by a long break
    push(1'b0, 1'b0, 1'b1, 8'hA5, 0, 0);
    send_frame(8'h00, 1'b0, 1'b0);
    RxD = 1'b0;
    repeat (33 * BIT_CLK) @(negedge clk);
    check("break_data", 32'(Rx_DATA), 32'hA5);
    idle_bits(1);
    push(1'b1, 1'b0, 1'b0, 8'h81, 0, 0);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(1);

    // Glitch of 4 ticks
    RxD = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    idle_bits(1);
    push(1'b1, 1'b0, 1'b0, 8'h5A, 0, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle_bits(1);

    // Back-to-back frames with no idle gap
    push(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
    push(1'b1, 1'b0, 1'b0, 8'hFF, 0, GAP_NOM);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_bits(1);

    // Rx_EN dropped during data bit 3
    fork
      send_frame(8'h77, 1'b0, 1'b1);
      begin
        repeat (4 * BIT_CLK + 200) @(negedge clk);
        Rx_EN = 1'b0;
      end
    join
    Rx_EN = 1'b1;
    idle_bits(1);
    check("abort_data", 32'(Rx_DATA), 32'hFF);

    // Reset pulse during the parity bit
    fork
      send_frame(8'h11, 1'b0, 1'b1);
      begin
        repeat (9 * BIT_CLK + 100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_data", 32'(Rx_DATA), 32'h0);
        check("midreset_flags", 32'({Rx_VALID, Rx_PERROR, Rx_FERROR}), 32'h0);
      end
    join
    idle_bits(1);
    push(1'b1, 1'b0, 1'b0, 8'h22, 0, 0);
    send_frame(8'h22, 1'b0, 1'b1);
    idle_bits(2);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive channel. It deserialises one asynchronous line into 8-bit bytes with even parity, framed as 1 start, 8 data (LSB first), 1 parity and 1 stop bit. All bit timing comes from the 16x-oversampling sample_ENABLE strobe, which the baud_controller produces in the same clock domain. It sits beside the transmitter in the UART top level and presents each byte with a one-cycle valid pulse and error pulses.

Parameters:
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, sample_ENABLE ticks per bit period
MID_TICK, 7, tick index (0-based) within the start bit at which mid-bit is checked

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
Rx_EN  input  1  receiver enable; low forces IDLE
RxD  input  1  serial line, asynchronous, idle high
sample_ENABLE  input  1  one-clk strobe at 16x baud from baud_controller
Rx_DATA  output  8  last correctly received byte
Rx_VALID  output  1  one-clk pulse: Rx_DATA updated with a good frame
Rx_PERROR  output  1  one-clk pulse: parity mismatch
Rx_FERROR  output  1  one-clk pulse: stop bit sampled low

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - Rx_DATA=0; Rx_VALID, Rx_PERROR, Rx_FERROR = 0.
  - State IDLE; tick and bit counters = 0; armed = 0; synchroniser flops = 1.
- Synchronisation: RxD passes through a 2-flop synchroniser (rxd_s), adding 2 clk of latency. All decisions use rxd_s.
- Tick gating: counters and state advance only on clk edges where sample_ENABLE=1. Output pulses last exactly one clk.
- IDLE:
  - On a tick with rxd_s=1, set armed=1.
  - On a tick with armed=1, Rx_EN=1 and rxd_s=0, go to START with tick_cnt=0.
- START:
  - Count ticks. At tick_cnt=MID_TICK, if rxd_s=0, go to DATA with tick_cnt=0 and bit_cnt=0.
  - Otherwise it is a glitch: go to IDLE with no pulse.
- DATA:
  - Every OVERSAMPLE ticks (tick_cnt wraps 15->0), sample rxd_s into shift-register position bit_cnt (LSB first).
  - After bit_cnt=DATA_BITS-1, go to PARITY.
- PARITY: 16 ticks later, sample the parity bit. Expected value = XOR of the 8 data bits (even parity). Store the mismatch flag; go to STOP.
- STOP: 16 ticks later, sample the stop bit, then act on the same clk:
  - stop=1 and parity OK: Rx_DATA <= shift register; Rx_VALID=1.
  - parity mismatch: Rx_PERROR=1.
  - stop=0: Rx_FERROR=1.
  - Both errors may pulse together. Rx_DATA is unchanged on any error.
  - Return to IDLE. armed = stop bit value, so a break (line held low) is not re-detected as a start until the line returns high.
- Frame completes at mid-stop, so a start bit immediately after the stop bit is caught (back-to-back frames).
- Rx_EN=0 in any non-IDLE state: abort to IDLE on the next clk, no pulses, Rx_DATA held.
- Reset mid-frame: all state cleared next clk; no pulse is emitted.
- sample_ENABLE and a state change never overlap ambiguously; the counter width is 4 bits for ticks and 3 bits for bits, both wrapping naturally.

Decomposition:
- Package uart_pkg holds:
  - DATA_BITS and OVERSAMPLE constants.
  - The state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, as 3 bits.
  - An even_parity function shared with the transmitter.
- Sub-module uart_sync2 is the 2-flop synchroniser. Its reset value is 1, and the transmitter side reuses it for CTS-style inputs.
- baud_controller is instantiated by the top level, not inside this block.

Test Plan:
(Bench uses 50 MHz clk with a baud_controller at baud_select=3'b111, i.e. sample_ENABLE every 27 clk and one bit = 432 clk.)
- Good frame: send 0xA5 with parity 0 and stop 1 -> one Rx_VALID pulse; Rx_DATA=0xA5; no error pulses; pulse lands 10.5 bit times (±1 tick + 2 clk) after the falling edge.
- Parity error: send 0x3C with parity 1 -> Rx_PERROR pulse only; Rx_VALID stays 0; Rx_DATA keeps 0xA5.
- Framing error and break: send 0x00 with parity 0 and stop 0, then hold RxD low for 3 frame times -> single Rx_FERROR pulse; no further activity until RxD goes high and a new frame 0x81 is sent -> Rx_VALID, Rx_DATA=0x81.
- Glitch rejection: RxD low for 4 ticks, then high -> state returns to IDLE; no pulses. A following frame 0x5A is received correctly.
- Back-to-back: 0x00 then 0xFF with zero idle gap -> two Rx_VALID pulses about 11 bit times apart; Rx_DATA=0x00 then 0xFF.
- Abort cases:
  - Rx_EN dropped during data bit 3 of 0x77 -> no pulses.
  - reset asserted for 1 clk during parity of 0x11 -> all outputs 0 next clk and no pulse; the next frame 0x22 is received correctly.
